// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the uart core's txd/txv, paced on rdy; one txv pulse per byte, never back-to-back.
// Write-to-txv latency is 1 edge minimum; host writes into a full FIFO are dropped and flagged sticky. Define UART_TX_FIFO_STATUS_EN for level/afull.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_WAIT    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] txd,
  output logic                  txv,
  input  logic                  rdy
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  afull
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_RDY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [TW-1:0]         timer;
  state_t                state;
  logic                  push;
  logic                  pop;

  // full/empty are registered, so a write into a full FIFO is dropped even if a pop frees a slot that cycle
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && rdy;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // A byte whose rdy never drops within BUSY_WAIT cycles is taken as accepted, not resent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      txd   <= '0;
      txv   <= 1'b0;
    end else begin
      txv <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            txd   <= mem[rd_ptr];
            txv   <= 1'b1;
            timer <= TW'(BUSY_WAIT);
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!rdy)              state <= WAIT_RDY;
          else if (timer == '0)  state <= IDLE;
          else                   timer <= timer - 1'b1;
        end
        WAIT_RDY: begin
          if (rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  localparam logic [DEPTH_LOG2:0] AFULL_CNT = AFULL_THRESH[DEPTH_LOG2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      afull <= 1'b0;
    end else begin
      level <= count_nxt;
      afull <= (count_nxt >= AFULL_CNT);
    end
  end
`endif

endmodule
